bus_master_if: RTL and testbench

// Master-side bus interface: turns a single-transaction CPU-side access request into the bus master protocol.

---
 rtl/bus_master_if.sv | 135 +++++++++++++
 tb/tb_bus_master_if.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bus_master_if.sv
// Master-side bus interface: converts a single CPU access request into the
// req_/grnt_ -> as_ -> rdy_ bus protocol, with an optional ready timeout.
module bus_master_if #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [29:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [31:0] cpu_wr_data,
    output logic [31:0] cpu_rd_data,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        bus_req_,
    input  logic        bus_grnt_,
    output logic [29:0] bus_addr,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_
);

    typedef enum logic [1:0] {IDLE, REQ, ACCESS, WAIT} state_t;

    state_t             state, state_n;
    logic [29:0]        lat_addr, lat_addr_n;
    logic               lat_rw, lat_rw_n;
    logic [31:0]        lat_wdata, lat_wdata_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [31:0]        cpu_rd_data_n;
    logic               cpu_done_n, cpu_err_n;
    logic               bus_req_n, bus_as_n, bus_rw_n;
    logic [29:0]        bus_addr_n;
    logic [31:0]        bus_wr_data_n;
    logic               timeout_hit;

    assign cpu_busy    = (state != IDLE);
    // TIMEOUT == 0 disables the abort path entirely
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lat_addr    <= '0;
            lat_rw      <= 1'b1;
            lat_wdata   <= '0;
            cnt         <= '0;
            cpu_rd_data <= '0;
            cpu_done    <= 1'b0;
            cpu_err     <= 1'b0;
            bus_req_    <= 1'b1;
            bus_as_     <= 1'b1;
            bus_addr    <= '0;
            bus_rw      <= 1'b1;
            bus_wr_data <= '0;
        end else begin
            state       <= state_n;
            lat_addr    <= lat_addr_n;
            lat_rw      <= lat_rw_n;
            lat_wdata   <= lat_wdata_n;
            cnt         <= cnt_n;
            cpu_rd_data <= cpu_rd_data_n;
            cpu_done    <= cpu_done_n;
            cpu_err     <= cpu_err_n;
            bus_req_    <= bus_req_n;
            bus_as_     <= bus_as_n;
            bus_addr    <= bus_addr_n;
            bus_rw      <= bus_rw_n;
            bus_wr_data <= bus_wr_data_n;
        end
    end

    always_comb begin
        state_n       = state;
        lat_addr_n    = lat_addr;
        lat_rw_n      = lat_rw;
        lat_wdata_n   = lat_wdata;
        cnt_n         = cnt;
        cpu_rd_data_n = cpu_rd_data;
        cpu_done_n    = 1'b0;
        cpu_err_n     = 1'b0;
        bus_req_n     = bus_req_;
        bus_as_n      = 1'b1;
        bus_addr_n    = bus_addr;
        bus_rw_n      = bus_rw;
        bus_wr_data_n = bus_wr_data;

        case (state)
            IDLE: begin
                if (cpu_req) begin
                    lat_addr_n  = cpu_addr;
                    lat_rw_n    = cpu_rw;
                    lat_wdata_n = cpu_wr_data;
                    bus_req_n   = 1'b0;
                    state_n     = REQ;
                end
            end
            REQ: begin
                if (!bus_grnt_) begin
                    bus_addr_n    = lat_addr;
                    bus_rw_n      = lat_rw;
                    bus_wr_data_n = lat_wdata;
                    bus_as_n      = 1'b0;
                    cnt_n         = '0;
                    state_n       = ACCESS;
                end
            end
            ACCESS, WAIT: begin
                // Ready has priority over a simultaneous timeout
                if (!bus_rdy_ || timeout_hit) begin
                    if (!bus_rdy_) begin
                        if (lat_rw) cpu_rd_data_n = bus_rd_data;
                        cpu_done_n = 1'b1;
                    end else begin
                        cpu_err_n = 1'b1;
                    end
                    bus_req_n     = 1'b1;
                    bus_addr_n    = '0;
                    bus_wr_data_n = '0;
                    bus_rw_n      = 1'b1;
                    state_n       = IDLE;
                end else begin
                    cnt_n   = cnt + 1'b1;
                    state_n = WAIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: per-cycle protocol checks plus a
// completion scoreboard fed at request time and drained on done/err pulses.
module tb_bus_master_if;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [29:0] cpu_addr;
    logic        cpu_rw;
    logic [31:0] cpu_wr_data;
    logic [31:0] cpu_rd_data;
    logic        cpu_busy, cpu_done, cpu_err;
    logic        bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data, bus_rd_data;

    bus_master_if #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
        .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
        .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_rd   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && (cpu_done || cpu_err)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL sb_unexpected observed done=%b err=%b expected no pulse", cpu_done, cpu_err);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_err", 64'(cpu_err), 64'(mon_e.err));
                chk("sb_rd_data", 64'(cpu_rd_data), 64'(mon_e.rd));
            end
        end
    end

    // One transaction: grant after gdel REQ cycles, ready rdel cycles after as_
    // (rdel >= TIMEOUT means ready never arrives).
    task automatic run_txn(input string tag, input logic rw, input logic [29:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int unsigned gdel, input int unsigned rdel);
        logic err_exp;
        err_exp = (rdel >= TIMEOUT);
        if (!err_exp && rw) exp_rd = rd;
        sb.push_back('{err_exp, exp_rd});

        cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wr_data = wd;
        bus_rd_data = 32'h5A5A_A5A5;
        tick();
        cpu_req = 1'b0; cpu_addr = ~addr; cpu_wr_data = ~wd; cpu_rw = ~rw;
        for (int i = 0; i < int'(gdel); i++) begin
            bus_rdy_ = 1'b0;    // stray ready while requesting must be ignored
            chk($sformatf("%s_req%0d", tag, i), {62'b0, bus_req_, bus_as_}, 64'b01);
            tick();
        end
        chk($sformatf("%s_grant", tag), {61'b0, cpu_busy, bus_req_, bus_as_}, 64'b101);
        bus_grnt_ = 1'b0;
        tick();
        bus_grnt_ = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus_rdy_    = (k == int'(rdel)) ? 1'b0 : 1'b1;
            bus_rd_data = (k == int'(rdel)) ? rd : 32'h5A5A_A5A5;
            chk($sformatf("%s_acc%0d", tag, k), {31'b0, bus_as_, bus_req_, bus_rw, bus_addr},
                {31'b0, (k == 0) ? 1'b0 : 1'b1, 1'b0, rw, addr});
            chk($sformatf("%s_wd%0d", tag, k), 64'(bus_wr_data), 64'(wd));
            tick();
            if (k == int'(rdel) || k == int'(TIMEOUT) - 1) break;
        end
        bus_rdy_ = 1'b1;
        chk($sformatf("%s_pulse", tag), {62'b0, cpu_done, cpu_err}, {62'b0, ~err_exp, err_exp});
        chk($sformatf("%s_release", tag), {bus_as_, bus_req_, bus_rw, cpu_busy, bus_addr, bus_wr_data},
            {1'b1, 1'b1, 1'b1, 1'b0, 30'b0, 32'b0});
        tick();
        chk($sformatf("%s_pulse_end", tag), {62'b0, cpu_done, cpu_err}, 64'b0);
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_rw = 1'b1; cpu_wr_data = '0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
        tick();
        tick();
        chk("reset_outs", {cpu_busy, cpu_done, cpu_err, bus_req_, bus_as_, bus_rw, bus_addr},
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 30'b0});
        chk("reset_data", {bus_wr_data, cpu_rd_data}, 64'b0);
        reset = 1'b0;
        tick();

        run_txn("t1_read",    1'b1, 30'h0800_0004, 32'h0,         32'hDEAD_BEEF, 0, 0);
        run_txn("t2_write",   1'b0, 30'h1000_0010, 32'h1234_5678, 32'hFFFF_FFFF, 4, 1);
        run_txn("t3_read",    1'b1, 30'h2000_0100, 32'hCAFE_0000, 32'h0BAD_F00D, 0, 3);
        run_txn("t4_timeout", 1'b1, 30'h3000_0008, 32'h0,         32'h7777_7777, 1, 99);
        run_txn("t5_lastcyc", 1'b1, 30'h3800_000C, 32'h0,         32'h1357_9BDF, 0, 15);

        // Reset while waiting for ready
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 30'h0400_0000; cpu_wr_data = 32'hAAAA_5555;
        tick();
        cpu_req = 1'b0; bus_grnt_ = 1'b0;
        tick();
        bus_grnt_ = 1'b1;
        tick();
        tick();
        chk("t6_in_wait", {62'b0, cpu_busy, bus_req_}, 64'b10);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_outs", {cpu_busy, cpu_done, cpu_err, bus_req_, bus_as_, bus_rw, bus_addr},
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 30'b0});
        chk("t6_async_data", {bus_wr_data, cpu_rd_data}, 64'b0);
        exp_rd = '0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        run_txn("t6_after", 1'b1, 30'h0C00_0040, 32'h0, 32'h2468_ACE0, 0, 0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
